// File: rtl/tb_in_arb.sv
// -----------------------------------------------------------------------------
// tb_in_arb
// Two-source round-robin arbiter and sequencer feeding the cb_seg input port.
// A granted transport block is announced with a one-cycle size write and then
// streamed bit by bit. An idle gap follows before the next grant decision.
// Requests with an illegal size are rejected with a one-cycle pulse.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req[1:0]            request level per source, looked at only in IDLE
//   size0, size1        TB size in bits per source, valid while req[k]
//   data0, data1        serial TB bit per source, valid whenever ren[k]=1
//   gnt[1:0]            one-hot grant, held from the SIZE cycle to the last DATA cycle
//   ren[1:0]            per-source bit-read strobe (one bit consumed per cycle)
//   rej[1:0]            one-cycle pulse: request rejected, size out of range
//   wreq_size           size write strobe; tb_size_in carries the size, else 0
//   tb_size_in[15:0]    size toward cb_seg
//   wreq_data           data write strobe; tb_in carries the bit, else 0
//   tb_in               serial data toward cb_seg
//   busy                high in every state except IDLE
//   tb_count[7:0]       completed transfers, wraps 255 -> 0
//   dbg_state[1:0]      current FSM state (0=IDLE 1=SIZE 2=DATA 3=GAP)
//
// Strobe semantics: there is no backpressure. wreq_size and wreq_data are
// write-enable pulses; a transfer happens in every cycle the strobe is high
// and the associated payload is forced to 0 in every other cycle.
// -----------------------------------------------------------------------------
module tb_in_arb #(
  parameter int MIN_SIZE = 40,
  parameter int MAX_SIZE = 24576,
  parameter int GAP      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] size0,
  input  logic [15:0] size1,
  input  logic        data0,
  input  logic        data1,
  output logic [1:0]  gnt,
  output logic [1:0]  ren,
  output logic [1:0]  rej,
  output logic        wreq_size,
  output logic [15:0] tb_size_in,
  output logic        wreq_data,
  output logic        tb_in,
  output logic        busy,
  output logic [7:0]  tb_count,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] MIN_S  = 16'(MIN_SIZE);
  localparam logic [15:0] MAX_S  = 16'(MAX_SIZE);
  localparam logic [15:0] GAP_M1 = 16'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SIZE = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_prio;      // index of the source that wins a tie
  logic        r_owner;     // source of the transfer in flight
  logic [15:0] r_size;
  logic [15:0] r_bit_cnt;
  logic [15:0] r_gap_cnt;
  logic [1:0]  r_gnt;
  logic [1:0]  r_ren;
  logic [1:0]  r_rej;
  logic        r_wreq_size;
  logic [15:0] r_tb_size;
  logic        r_wreq_data;
  logic        r_tb_in;
  logic        r_busy;
  logic [7:0]  r_tb_count;

  logic        w_pick;
  logic [15:0] w_size;
  logic        w_legal;
  logic [1:0]  w_pick_oh;

  // Candidate selection for the IDLE decision. A lone request wins outright;
  // with both requesting, the pointer decides.
  always_comb begin
    w_pick = 1'b0;
    if (req == 2'b11) begin
      w_pick = r_prio;
    end else if (req[1]) begin
      w_pick = 1'b1;
    end
    w_size    = w_pick ? size1 : size0;
    w_legal   = (w_size >= MIN_S) && (w_size <= MAX_S);
    w_pick_oh = w_pick ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_owner     <= 1'b0;
      r_size      <= 16'd0;
      r_bit_cnt   <= 16'd0;
      r_gap_cnt   <= 16'd0;
      r_gnt       <= 2'b00;
      r_ren       <= 2'b00;
      r_rej       <= 2'b00;
      r_wreq_size <= 1'b0;
      r_tb_size   <= 16'd0;
      r_wreq_data <= 1'b0;
      r_tb_in     <= 1'b0;
      r_busy      <= 1'b0;
      r_tb_count  <= 8'd0;
    end else begin
      // Pulses default low; the data path is ren/data delayed by one cycle,
      // so wreq_data trails ren and the last bit lands in the first GAP cycle.
      r_wreq_size <= 1'b0;
      r_tb_size   <= 16'd0;
      r_rej       <= 2'b00;
      r_wreq_data <= |r_ren;
      r_tb_in     <= (r_ren[0] & data0) | (r_ren[1] & data1);

      case (r_state)
        S_IDLE: begin
          if (|req) begin
            if (w_legal) begin
              r_owner     <= w_pick;
              r_size      <= w_size;
              r_gnt       <= w_pick_oh;
              r_wreq_size <= 1'b1;
              r_tb_size   <= w_size;
              r_busy      <= 1'b1;
              r_state     <= S_SIZE;
            end else begin
              // Skip past the rejected source so the other one gets the next look.
              r_rej  <= w_pick_oh;
              r_prio <= ~w_pick;
            end
          end
        end

        S_SIZE: begin
          r_bit_cnt <= r_size - 16'd1;
          r_ren     <= r_gnt;
          r_state   <= S_DATA;
        end

        S_DATA: begin
          if (r_bit_cnt == 16'd0) begin
            r_ren     <= 2'b00;
            r_gnt     <= 2'b00;
            r_gap_cnt <= GAP_M1;
            r_state   <= S_GAP;
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == 16'd0) begin
            r_busy     <= 1'b0;
            r_tb_count <= r_tb_count + 8'd1;
            r_prio     <= ~r_owner;
            r_state    <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign ren        = r_ren;
  assign rej        = r_rej;
  assign wreq_size  = r_wreq_size;
  assign tb_size_in = r_tb_size;
  assign wreq_data  = r_wreq_data;
  assign tb_in      = r_tb_in;
  assign busy       = r_busy;
  assign tb_count   = r_tb_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_tb_in_arb.sv
// -----------------------------------------------------------------------------
// tb_tb_in_arb
// Bench for tb_in_arb. Driver tasks issue directed requests and push the
// expected size writes, data bits (with cycle stamps), reject pulses and
// busy-fall events into queues; an independent monitor pops and compares
// whenever the DUT presents the corresponding strobe.
// -----------------------------------------------------------------------------
module tb_tb_in_arb;

  localparam int GAP = 4;

  // ---------------- clock / reset block ----------------
  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] size0, size1;
  logic        data0, data1;
  logic [1:0]  gnt, ren, rej;
  logic        wreq_size, wreq_data, tb_in, busy;
  logic [15:0] tb_size_in;
  logic [7:0]  tb_count;
  logic [1:0]  dbg_state;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int count_model = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  tb_in_arb #(.MIN_SIZE(40), .MAX_SIZE(24576), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .size0(size0), .size1(size1),
    .data0(data0), .data1(data1), .gnt(gnt), .ren(ren), .rej(rej),
    .wreq_size(wreq_size), .tb_size_in(tb_size_in), .wreq_data(wreq_data),
    .tb_in(tb_in), .busy(busy), .tb_count(tb_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard queues ----------------
  logic [49:0] size_q[$];  // {gnt, size, cycle}
  logic [32:0] bit_q[$];   // {bit, cycle}
  logic [33:0] rej_q[$];   // {rej, cycle}
  logic [39:0] busy_q[$];  // {tb_count after fall, cycle of first idle}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Serial bit pattern served by source k for bit index i.
  function automatic logic pat(input int k, input int i);
    int v;
    v = i * 7 + k * 11 + (i >> 4);
    return v[0] ^ v[3] ^ v[5];
  endfunction

  // Expected results of a transfer decided in cycle t.
  task automatic push_xfer(input int k, input int n, input int t, input int nbits,
                           input bit with_busy);
    size_q.push_back({((k == 1) ? 2'b10 : 2'b01), 16'(n), 32'(t + 1)});
    for (int i = 0; i < nbits; i++) bit_q.push_back({pat(k, i), 32'(t + 3 + i)});
    if (with_busy) begin
      count_model = (count_model + 1) % 256;
      busy_q.push_back({8'(count_model), 32'(t + 2 + n + GAP)});
    end
  endtask

  // ---------------- data source driver ----------------
  int idx0, idx1;
  initial begin
    data0 = 1'b0;
    data1 = 1'b0;
    idx0 = 0;
    idx1 = 0;
    forever begin
      @(negedge clk);
      if (wreq_size) begin
        if (gnt[0]) idx0 = 0;
        if (gnt[1]) idx1 = 0;
      end
      if (ren[0]) begin data0 = pat(0, idx0); idx0++; end
      if (ren[1]) begin data1 = pat(1, idx1); idx1++; end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [49:0] es;
    logic [32:0] eb;
    logic [33:0] er;
    logic [39:0] eq;
    logic        prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wreq_size) begin
        if (size_q.size() == 0) fail_now("unexpected_wreq_size", tb_size_in);
        else begin
          es = size_q.pop_front();
          chk("size_cycle", cyc, es[31:0]);
          chk("size_value", tb_size_in, es[47:32]);
          chk("size_gnt", gnt, es[49:48]);
        end
      end
      if (wreq_data) begin
        if (bit_q.size() == 0) fail_now("unexpected_wreq_data", tb_in);
        else begin
          eb = bit_q.pop_front();
          chk("data_cycle", cyc, eb[31:0]);
          chk("data_bit", tb_in, eb[32]);
        end
      end
      if (rej != 2'b00) begin
        if (rej_q.size() == 0) fail_now("unexpected_rej", rej);
        else begin
          er = rej_q.pop_front();
          chk("rej_cycle", cyc, er[31:0]);
          chk("rej_value", rej, er[33:32]);
          chk("rej_busy", busy, 0);
        end
      end
      if (prev_busy && !busy) begin
        if (busy_q.size() == 0) fail_now("unexpected_busy_fall", tb_count);
        else begin
          eq = busy_q.pop_front();
          chk("busy_fall_cycle", cyc, eq[31:0]);
          chk("tb_count", tb_count, eq[39:32]);
        end
      end
      // {size/data overlap, gnt not onehot0, ren not onehot0, stray size, stray bit}
      chk("invariants", {(wreq_size & wreq_data), !$onehot0(gnt), !$onehot0(ren),
                         (!wreq_size && tb_size_in != 16'd0), (!wreq_data && tb_in)}, 0);
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy || size_q.size() != 0 || bit_q.size() != 0 ||
            rej_q.size() != 0 || busy_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("drain_timeout", n);
    repeat (2) @(negedge clk);
  endtask

  // Reset asserted at the current negedge; outputs checked one cycle later.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {gnt, ren, rej, wreq_size, tb_size_in, wreq_data, tb_in, busy}, 0);
    chk("reset_tb_count", tb_count, 0);
    chk("reset_state", dbg_state, 0);
    count_model = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : driver
    logic [1:0]  il_req [3];
    logic [15:0] il_s0  [3];
    logic [15:0] il_s1  [3];
    int t;
    int tn;
    il_req = '{2'b01, 2'b10, 2'b01};
    il_s0  = '{16'd39, 16'd0, 16'd0};
    il_s1  = '{16'd0, 16'd24577, 16'd0};

    reset = 1'b1;
    req   = 2'b00;
    size0 = 16'd0;
    size1 = 16'd0;
    @(negedge clk);
    do_reset();

    // Single source, 7010 bits.
    req = 2'b01; size0 = 16'd7010; t = cyc;
    push_xfer(0, 7010, t, 7010, 1'b1);
    @(negedge clk);
    req = 2'b00;
    drain(8000);

    // Both requesting from reset: 0,1,0,1 with sizes 40/1056.
    do_reset();
    req = 2'b11; size0 = 16'd40; size1 = 16'd1056; t = cyc;
    tn = t;
    for (int j = 0; j < 4; j++) begin
      push_xfer(j % 2, (j % 2 == 0) ? 40 : 1056, tn, (j % 2 == 0) ? 40 : 1056, 1'b1);
      if (j < 3) tn = tn + ((j % 2 == 0) ? 40 : 1056) + GAP + 2;
    end
    wait_cycle(tn + 1);
    req = 2'b00;
    drain(3000);

    // Illegal sizes.
    for (int j = 0; j < 3; j++) begin
      req = il_req[j]; size0 = il_s0[j]; size1 = il_s1[j]; t = cyc;
      rej_q.push_back({il_req[j], 32'(t + 1)});
      @(negedge clk);
      req = 2'b00;
      drain(20);
    end
    req = 2'b01; size0 = 16'd24576; t = cyc;
    push_xfer(0, 24576, t, 24576, 1'b1);
    @(negedge clk);
    req = 2'b00;
    drain(26000);

    // req0 dropped and size0 changed during DATA.
    req = 2'b01; size0 = 16'd1056; t = cyc;
    push_xfer(0, 1056, t, 1056, 1'b1);
    wait_cycle(t + 100);
    req = 2'b00; size0 = 16'd100;
    drain(1500);

    // Reset while bit 500 of 6144 is being read.
    req = 2'b01; size0 = 16'd6144; t = cyc;
    push_xfer(0, 6144, t, 500, 1'b0);
    @(negedge clk);
    req = 2'b00;
    wait_cycle(t + 502);
    busy_q.push_back({8'd0, 32'(t + 503)});
    do_reset();
    req = 2'b11; size0 = 16'd40; size1 = 16'd40; t = cyc;
    push_xfer(0, 40, t, 40, 1'b1);
    @(negedge clk);
    req = 2'b00;
    drain(200);

    // 256 back-to-back transfers of 40 bits: tb_count wraps to 0.
    do_reset();
    req = 2'b01; size0 = 16'd40; t = cyc;
    for (int j = 0; j < 256; j++) push_xfer(0, 40, t + 46 * j, 40, 1'b1);
    wait_cycle(t + 46 * 255 + 1);
    req = 2'b00;
    drain(13000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule
